// File: rtl/tetris_pkg.sv
// Shared Tetris game constants: piece count, ID width, piece IDs
// and the dealer FSM state type.
package tetris_pkg;

    localparam int NUM_PIECES = 7;
    localparam int PIECE_W    = 3;

    localparam logic [PIECE_W-1:0] PIECE_I = 3'd0;
    localparam logic [PIECE_W-1:0] PIECE_O = 3'd1;
    localparam logic [PIECE_W-1:0] PIECE_T = 3'd2;
    localparam logic [PIECE_W-1:0] PIECE_S = 3'd3;
    localparam logic [PIECE_W-1:0] PIECE_Z = 3'd4;
    localparam logic [PIECE_W-1:0] PIECE_J = 3'd5;
    localparam logic [PIECE_W-1:0] PIECE_L = 3'd6;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_GATHER = 1'b1
    } dealer_state_e;

endpackage

// File: rtl/piece_bag_mask.sv
// 7-bag bookkeeping: used-piece mask, lookup, bag-complete flag and
// lowest-unused priority encoder for the dealer fallback.
module piece_bag_mask #(
    parameter int NUM_PIECES = tetris_pkg::NUM_PIECES,
    parameter int PIECE_W    = tetris_pkg::PIECE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               set_i,
    input  logic [PIECE_W-1:0] set_idx_i,
    input  logic [PIECE_W-1:0] query_idx_i,
    output logic               used_o,
    output logic               fill_o,
    output logic [PIECE_W-1:0] lowest_o
);

    logic [NUM_PIECES-1:0] used_q;
    logic [NUM_PIECES-1:0] used_d;
    logic [NUM_PIECES-1:0] set_mask;

    always_comb begin
        set_mask = '0;
        used_o   = 1'b0;
        lowest_o = '0;
        for (int i = 0; i < NUM_PIECES; i++) begin
            set_mask[i] = (set_idx_i == PIECE_W'(i));
            if (query_idx_i == PIECE_W'(i)) begin
                used_o = used_q[i];
            end
        end
        // Descending scan so the lowest free index wins.
        for (int i = NUM_PIECES - 1; i >= 0; i--) begin
            if (!used_q[i]) begin
                lowest_o = PIECE_W'(i);
            end
        end
        fill_o = &(used_q | set_mask);
        used_d = used_q;
        if (set_i) begin
            used_d = fill_o ? '0 : (used_q | set_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_q <= '0;
        end else begin
            used_q <= used_d;
        end
    end

endmodule

// File: rtl/piece_dealer.sv
// Tetromino dealer: gathers serial random bits into candidates, retries
// with bounded fallback. Define BAG_EN to enable 7-bag selection.
module piece_dealer #(
    parameter int NUM_PIECES = tetris_pkg::NUM_PIECES,
    parameter int PIECE_W    = tetris_pkg::PIECE_W,
    parameter int MAX_TRIES  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rand_bit,
    input  logic               req,
    output logic [PIECE_W-1:0] piece,
    output logic               piece_valid,
    output logic               busy,
    output logic [PIECE_W-1:0] bag_count
);

    import tetris_pkg::*;

    localparam int BW = $clog2(PIECE_W + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);

    localparam logic [BW-1:0] BIT_LAST = BW'(PIECE_W - 1);
    localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
    localparam logic [PIECE_W-1:0] NP_L = PIECE_W'(NUM_PIECES);

    dealer_state_e      state_q;
    logic [PIECE_W-2:0] shift_q;
    logic [BW-1:0]      bit_cnt_q;
    logic [TW-1:0]      try_cnt_q;
    logic [PIECE_W-1:0] piece_q;
    logic               valid_q;
    logic               busy_q;

    logic [PIECE_W-1:0] cand;
    logic               cand_used;
    logic               cand_ok;
    logic [PIECE_W-1:0] fb_idx;
    logic [PIECE_W-1:0] deal_idx;
    logic               last_bit;
    logic               last_try;
    logic               deal;

    always_comb begin
        cand     = {shift_q, rand_bit};
        cand_ok  = (cand < NP_L) && !cand_used;
        last_bit = (bit_cnt_q == BIT_LAST);
        last_try = (try_cnt_q == TRY_LAST);
        deal     = (state_q == ST_GATHER) && last_bit
                   && (cand_ok || last_try);
        deal_idx = cand_ok ? cand : fb_idx;
    end

`ifdef BAG_EN
    logic               fill;
    logic [PIECE_W-1:0] bag_cnt_q;

    piece_bag_mask #(
        .NUM_PIECES (NUM_PIECES),
        .PIECE_W    (PIECE_W)
    ) u_bag (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_i       (deal),
        .set_idx_i   (deal_idx),
        .query_idx_i (cand),
        .used_o      (cand_used),
        .fill_o      (fill),
        .lowest_o    (fb_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bag_cnt_q <= '0;
        end else if (deal) begin
            bag_cnt_q <= fill ? '0 : bag_cnt_q + 1'b1;
        end
    end

    assign bag_count = bag_cnt_q;
`else
    assign cand_used = 1'b0;
    assign fb_idx    = PIECE_W'(PIECE_I);
    assign bag_count = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            try_cnt_q <= '0;
            piece_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q   <= ST_GATHER;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        try_cnt_q <= '0;
                    end
                end
                ST_GATHER: begin
                    shift_q <= cand[PIECE_W-2:0];
                    if (!last_bit) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end else if (deal) begin
                        piece_q <= deal_idx;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        // Reject: discard bits, start a fresh candidate.
                        try_cnt_q <= try_cnt_q + 1'b1;
                        bit_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign piece       = piece_q;
    assign piece_valid = valid_q;
    assign busy        = busy_q;

endmodule
